// File: rtl/cavium_ca_array.sv
// Hybrid per-cell-rule CA keystream register: seed load, silent warm-up, then one state per handshake.
// Latency: out_valid rises WARMUP+1 cycles after the load cycle; out_ready=0 freezes the state.
module cavium_ca_array #(
   parameter int WIDTH    = 32,
   parameter int WARMUP   = 16,
   parameter int PERIODIC = 0
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               load,
   input  logic [WIDTH-1:0]   seed,
   input  logic [3*WIDTH-1:0] rule_vec,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [WIDTH-1:0]   out_data,
   output logic               busy,
   output logic               seed_err
);

   localparam int CW = (WARMUP > 0) ? $clog2(WARMUP + 1) : 1;
   localparam logic [CW-1:0] LAST = (WARMUP > 0) ? CW'(WARMUP - 1) : '0;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_WARM = 2'd1,
      S_RUN  = 2'd2
   } fsm_t;

   fsm_t               fsm, fsm_nxt;
   logic [WIDTH-1:0]   ca, ca_nxt, ca_step;
   logic [3*WIDTH-1:0] rules;
   logic [CW-1:0]      cnt, cnt_nxt;
   logic               load_ok, load_bad;

   function automatic logic ca_rule(input logic [2:0] r, input logic a, input logic b,
                                    input logic c);
      case (r)
         3'd0:    ca_rule = a ^ b ^ c ^ (b & c);
         3'd1:    ca_rule = a ^ b;
         3'd2:    ca_rule = a ^ c;
         3'd3:    ca_rule = a ^ (b & c);
         3'd4:    ca_rule = a ^ b ^ c;
         3'd5:    ca_rule = a ^ b ^ (b & c);
         3'd6:    ca_rule = a ^ c ^ (b & c);
         default: ca_rule = a;
      endcase
   endfunction

   for (genvar i = 0; i < WIDTH; i++) begin : g_cell
      logic b, c;
      if (i == 0) begin : g_lo
         if (PERIODIC != 0) begin : g_wrap
            assign b = ca[WIDTH-1];
         end else begin : g_null
            assign b = 1'b0;
         end
      end else begin : g_lo_mid
         assign b = ca[i-1];
      end
      if (i == WIDTH - 1) begin : g_hi
         if (PERIODIC != 0) begin : g_wrap
            assign c = ca[0];
         end else begin : g_null
            assign c = 1'b0;
         end
      end else begin : g_hi_mid
         assign c = ca[i+1];
      end
      assign ca_step[i] = ca_rule(rules[3*i +: 3], ca[i], b, c);
   end

   assign load_ok  = load & (|seed);
   assign load_bad = load & ~(|seed);

   always_comb begin
      fsm_nxt = fsm;
      ca_nxt  = ca;
      cnt_nxt = cnt;
      case (fsm)
         S_WARM: begin
            ca_nxt  = ca_step;
            cnt_nxt = cnt + 1'b1;
            if (cnt == LAST) fsm_nxt = S_RUN;
         end
         S_RUN: begin
            if (out_valid && out_ready) ca_nxt = ca_step;
         end
         default: ;
      endcase
      // A rejected zero seed freezes everything for that cycle; a good seed overrides any handshake.
      if (load_bad) begin
         fsm_nxt = fsm;
         ca_nxt  = ca;
         cnt_nxt = cnt;
      end else if (load_ok) begin
         ca_nxt  = seed;
         cnt_nxt = '0;
         fsm_nxt = (WARMUP == 0) ? S_RUN : S_WARM;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fsm       <= S_IDLE;
         ca        <= '0;
         rules     <= '0;
         cnt       <= '0;
         out_valid <= 1'b0;
         busy      <= 1'b0;
         seed_err  <= 1'b0;
      end else begin
         fsm       <= fsm_nxt;
         ca        <= ca_nxt;
         cnt       <= cnt_nxt;
         if (load_ok) rules <= rule_vec;
         out_valid <= (fsm_nxt == S_RUN);
         busy      <= (fsm_nxt == S_WARM);
         seed_err  <= load_bad;
      end
   end

   assign out_data = ca;

endmodule

// File: doc/cavium_ca_array.md
Name: cavium_ca_array

Overview:
- Parametrised hybrid cellular-automaton (CA) register of WIDTH cells. Each cell has its own 3-bit rule, chosen from the team's eight-rule CA cell set.
- Seeded by a load strobe, then runs a configurable warm-up of silent steps. After warm-up it emits one CA state per valid/ready handshake.
- Used as the keystream/PRNG source feeding downstream mixing logic. It replaces scattered single-cell instances.

Parameters:
- WIDTH, 32, number of CA cells (≥3).
- WARMUP, 16, silent CA steps after a seed load before the first output (0 allowed).
- PERIODIC, 0, boundary mode: 0 = null boundary (out-of-range neighbour reads 0); 1 = periodic (cell 0 and cell WIDTH-1 are neighbours).

Ports:
- clk, input, 1, clock; all state updates on the rising edge.
- rst_n, input, 1, asynchronous active-low reset.
- load, input, 1, seed strobe; sampled every cycle.
- seed, input, WIDTH, initial CA state, captured when load=1.
- rule_vec, input, 3*WIDTH, per-cell rules; cell i uses bits [3i+2:3i]; captured when load=1.
- out_valid, output, 1, out_data holds a fresh CA state.
- out_ready, input, 1, consumer accepts out_data.
- out_data, output, WIDTH, current CA state.
- busy, output, 1, high during WARMUP.
- seed_err, output, 1, one-cycle pulse: an all-zero seed was rejected.

Behaviour:
- Reset (async, rst_n=0): state=0, rule register=0, warm-up counter=0, FSM=IDLE, out_valid=0, busy=0, seed_err=0, out_data=0.
- Cell update for cell i:
  - a = own bit; b = cell i-1; c = cell i+1.
  - At the boundaries, b of cell 0 and c of cell WIDTH-1 are 0 (PERIODIC=0) or wrapped (PERIODIC=1).
  - Next value by rule: 0: a^b^c^(b&c); 1: a^b; 2: a^c; 3: a^(b&c); 4: a^b^c; 5: a^b^(b&c); 6: a^c^(b&c); 7: a.
  - One "step" updates all cells simultaneously from the pre-step state.
- Rules are taken only from the internal rule register loaded at load. Changes to rule_vec at other times are ignored.
- FSM IDLE: out_valid=0. On load with seed≠0, capture seed and rules, clear the counter, go to WARMUP; if WARMUP=0, go directly to RUN.
- FSM WARMUP: busy=1, out_valid=0. One step per cycle with counter increment. After exactly WARMUP steps, go to RUN; the next cycle shows out_valid=1.
- FSM RUN: out_valid=1, out_data=state.
  - If out_valid&out_ready, perform one step that cycle; the new state is valid the next cycle and out_valid stays 1.
  - If out_ready=0, the state holds unchanged.
- Latency: out_valid rises WARMUP+1 cycles after the load cycle. Throughput is one word per cycle in RUN.
- Zero seed: load with seed=0 is rejected. Pulse seed_err for 1 cycle; state, rules and FSM are unchanged. All rules map the zero state to itself, so a zero seed would lock the array.
- Load priority: a valid load in WARMUP or RUN aborts the current operation.
  - Capture the new seed and rules, restart warm-up, and drop out_valid the next cycle.
  - A handshake in the same cycle as a load is discarded; the load wins.
- Counter sized $clog2(WARMUP+1); no wrap beyond WARMUP.
- rst_n assertion mid-WARMUP or mid-RUN returns to the reset values immediately, independent of clk.
- All outputs are registered; no combinational path from out_ready to out_valid.

Test Plan:
- WIDTH=8, PERIODIC=1, WARMUP=0, all rules 4, load seed 8'h01 → next cycle out_valid=1, out_data=8'h01; accept with out_ready=1 → out_data=8'h83, then 8'h45.
- Same with PERIODIC=0 → first output 8'h01, then 8'h03.
- WIDTH=8, WARMUP=2, PERIODIC=1, rules 4, seed 8'h01 → busy=1 for 2 cycles, first out_data=8'h45 at load+3 cycles.
- All rules 7, seed 8'hA5, out_ready toggled randomly → out_data constant 8'hA5; out_valid stays 1.
- Load seed 0 while in RUN with state 8'h83 → seed_err pulses once, out_data stays 8'h83, out_valid stays 1.
- Backpressure: out_ready=0 for 5 cycles → out_data frozen. Load mid-RUN with handshake in the same cycle → handshake discarded, warm-up restarts. rst_n pulse mid-WARMUP → all outputs 0 immediately.
